// File: rtl/led_step_gen.sv
// Control stage for the 4-LED shift pipe: step strobe generation, shift
// direction / fill bit, and a debounced pushbutton that cycles display modes.
module led_step_gen #(
  parameter int DIV   = 4,
  parameter int DEB   = 3,
  parameter int WIDTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_n,
  output logic       step,
  output logic       dir,
  output logic       ser_in,
  output logic [1:0] mode
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = $clog2(DEB + 1);
  localparam int PW = $clog2(WIDTH);

  localparam logic [CW-1:0] CNT_LAST    = CW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB - 1);
  localparam logic [PW-1:0] POS_LAST    = PW'(WIDTH - 1);
  localparam logic [PW-1:0] BOUNCE_LAST = PW'(WIDTH - 2);

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    PAUSE  = 2'd3
  } mode_t;

  mode_t          state_q, state_d;
  logic           sync1_q, sync2_q;
  logic           deb_q;
  logic [DW-1:0]  deb_cnt_q;
  logic           press_q;
  logic [CW-1:0]  count_q;
  logic [PW-1:0]  pos_q;
  logic           bdir_q;
  logic           tick;
  logic           accept;
  logic           dir_d;

  // A level change is accepted on the DEB-th consecutive differing sample.
  assign accept = (sync2_q != deb_q) && (deb_cnt_q == DEB_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b1;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      press_q <= accept && !sync2_q;
      if (sync2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (accept) begin
        deb_q     <= sync2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ROT_L;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (press_q) begin
      case (state_q)
        ROT_L:   state_d = ROT_R;
        ROT_R:   state_d = BOUNCE;
        BOUNCE:  state_d = PAUSE;
        default: state_d = ROT_L;
      endcase
    end
  end

  assign tick = (state_q != PAUSE) && (count_q == CNT_LAST);

  always_comb begin
    dir_d = 1'b0;
    case (state_q)
      ROT_R:   dir_d = 1'b1;
      BOUNCE:  dir_d = bdir_q;
      default: dir_d = 1'b0;
    endcase
  end

  // A press restarts the step timeline; a tick coinciding with it is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      pos_q   <= '0;
      bdir_q  <= 1'b0;
    end else if (press_q) begin
      count_q <= '0;
      pos_q   <= '0;
      bdir_q  <= 1'b0;
    end else if (state_q == PAUSE) begin
      count_q <= '0;
    end else begin
      count_q <= tick ? '0 : count_q + 1'b1;
      if (tick) begin
        if (state_q == BOUNCE) begin
          if (pos_q == BOUNCE_LAST) begin
            pos_q  <= '0;
            bdir_q <= ~bdir_q;
          end else begin
            pos_q <= pos_q + 1'b1;
          end
        end else begin
          pos_q <= (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step   <= 1'b0;
      ser_in <= 1'b0;
      dir    <= 1'b0;
    end else begin
      step   <= tick && !press_q;
      ser_in <= tick && !press_q && (pos_q == '0);
      if (tick && !press_q) dir <= dir_d;
    end
  end

  assign mode = state_q;

endmodule

// File: tb/tb_led_step_gen.sv
// Randomized bench for led_step_gen: an edge-level behavioural model predicts
// every output cycle, a monitor compares on the falling edge.
module tb_led_step_gen;

  localparam int DIV   = 4;
  localparam int DEB   = 3;
  localparam int WIDTH = 4;

  logic       clock;
  logic       reset_n;
  logic       key_n;
  logic       step;
  logic       dir;
  logic       ser_in;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];

  led_step_gen #(.DIV(DIV), .DEB(DEB), .WIDTH(WIDTH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .key_n  (key_n),
    .step   (step),
    .dir    (dir),
    .ser_in (ser_in),
    .mode   (mode)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int m_t, m_anchor, m_mode, k;
  bit m_d1, m_d2, m_level, m_press, m_dir, e_step, e_ser, v, flip;
  bit m_hist[$];

  task automatic model_reset();
    m_t = 0; m_anchor = 0; m_mode = 0;
    m_d1 = 1'b1; m_d2 = 1'b1; m_level = 1'b1; m_press = 1'b0; m_dir = 1'b0;
    m_hist.delete();
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        m_t++;
        v = m_d2; m_d2 = m_d1; m_d1 = key_n;
        m_hist.push_back(v);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        e_step = 1'b0; e_ser = 1'b0;
        if (m_press) begin
          m_mode   = (m_mode + 1) % 4;
          m_anchor = m_t;
          m_press  = 1'b0;
        end else if (m_mode != 3 && ((m_t - m_anchor) % DIV) == 0) begin
          k = (m_t - m_anchor) / DIV;
          e_step = 1'b1;
          if (m_mode == 2) begin
            e_ser = ((k - 1) % (WIDTH - 1)) == 0;
            m_dir = ((((k - 1) / (WIDTH - 1)) % 2) == 1);
          end else begin
            e_ser = ((k - 1) % WIDTH) == 0;
            m_dir = (m_mode == 1);
          end
        end
        if (m_hist.size() == DEB) begin
          flip = 1'b1;
          foreach (m_hist[i]) if (m_hist[i] == m_level) flip = 1'b0;
          if (flip) begin
            m_level = !m_level;
            if (!m_level) m_press = 1'b1;
          end
        end
        exp_q.push_back({2'(m_mode), m_dir, e_ser, e_step});
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [4:0] exp_w, act_w;
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        act_w = {mode, dir, ser_in, step};
        checks++;
        if (act_w !== exp_w) begin
          errors++;
          $display("FAIL cycle t=%0t actual mode=%0d dir=%0b ser_in=%0b step=%0b expected mode=%0d dir=%0b ser_in=%0b step=%0b",
                   $time, act_w[4:3], act_w[2], act_w[1], act_w[0],
                   exp_w[4:3], exp_w[2], exp_w[1], exp_w[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic hold_key(input logic val, input int cycles);
    key_n = val;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic press(input int low_cycles, input int gap);
    hold_key(1'b0, low_cycles);
    hold_key(1'b1, gap);
  endtask

  // ---------------- stimulus ----------------
  int lat;
  logic [1:0] old_mode;

  initial begin
    key_n   = 1'b1;
    reset_n = 1'b0;
    #1;
    check_val("reset_step", step, 0);
    check_val("reset_mode", mode, 0);
    check_val("reset_dir", dir, 0);
    check_val("reset_ser_in", ser_in, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // free run
    repeat (40) @(negedge clock);

    // clean press with latency measurement
    old_mode = mode;
    key_n = 1'b0;
    lat = 0;
    while (mode == old_mode && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check_val("press_latency", lat, 2 + DEB + 1);
    check_val("mode_after_press", mode, 1);
    @(negedge clock);
    hold_key(1'b0, 3);
    hold_key(1'b1, 30);

    // glitch rejection, then a long hold
    repeat (3) begin
      hold_key(1'b0, 2);
      hold_key(1'b1, 2);
    end
    hold_key(1'b1, 10);
    check_val("mode_after_glitches", mode, 1);
    press(50, 20);
    check_val("mode_after_hold", mode, 2);

    // BOUNCE observed above; PAUSE, then wrap to ROT_L
    press(8, 50);
    check_val("mode_pause", mode, 3);
    press(8, 30);
    check_val("mode_wrap", mode, 0);

    // randomized key activity
    for (int i = 0; i < 300; i++) begin
      hold_key(1'(($urandom_range(0, 1))), $urandom_range(1, 12));
    end
    hold_key(1'b1, 20);

    // async reset while step is high
    lat = 0;
    while (!(step && mode != 3) && lat < 200) begin
      if (mode == 3) press(8, 10);
      @(posedge clock);
      #1;
      lat++;
    end
    check_val("step_seen_before_reset", step, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("async_reset_step", step, 0);
    check_val("async_reset_mode", mode, 0);
    check_val("async_reset_dir", dir, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    press(8, 30);
    check_val("mode_after_reset_press", mode, 1);

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
